ps2key_digit_rx: RTL and testbench

//  Serial PS/2 keyboard receiver with scan-code-to-digit decode.
//  - Samples raw ps2_clk/ps2_data and frames 11-bit packets.
//  - Checks start, odd parity and stop bits.
//  - Tracks E0 (extended) and F0 (break) prefixes; emits one strobe per digit-key press.
//  - Sits between the PS/2 connector pins and the digit-entry/display logic.

---
 rtl/ps2key_digit_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2key_digit_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2key_digit_rx.sv
// PS/2 keyboard receiver: synchronises and filters the pins, frames 11-bit packets,
// checks start/odd-parity/stop, and decodes digit make codes behind E0/F0 prefix tracking.
module ps2key_digit_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter bit KEYPAD_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       key_valid,
  output logic [3:0] key_digit,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          frame_err_q, frame_err_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_digit_q, key_digit_d;
  logic [4:0]    dec;

  // Returns {hit, digit} for a scan byte; keypad codes only count when enabled.
  function automatic logic [4:0] digit_of(input logic [7:0] code);
    logic [4:0] r;
    r = 5'h0;
    case (code)
      8'h16: r = {1'b1, 4'd1};
      8'h1E: r = {1'b1, 4'd2};
      8'h26: r = {1'b1, 4'd3};
      8'h25: r = {1'b1, 4'd4};
      8'h2E: r = {1'b1, 4'd5};
      8'h36: r = {1'b1, 4'd6};
      8'h3D: r = {1'b1, 4'd7};
      8'h3E: r = {1'b1, 4'd8};
      8'h46: r = {1'b1, 4'd9};
      8'h45: r = {1'b1, 4'd0};
      8'h69: r = {KEYPAD_EN, 4'd1};
      8'h72: r = {KEYPAD_EN, 4'd2};
      8'h7A: r = {KEYPAD_EN, 4'd3};
      8'h6B: r = {KEYPAD_EN, 4'd4};
      8'h73: r = {KEYPAD_EN, 4'd5};
      8'h74: r = {KEYPAD_EN, 4'd6};
      8'h6C: r = {KEYPAD_EN, 4'd7};
      8'h75: r = {KEYPAD_EN, 4'd8};
      8'h7D: r = {KEYPAD_EN, 4'd9};
      8'h70: r = {KEYPAD_EN, 4'd0};
      default: r = 5'h0;
    endcase
    return r;
  endfunction

  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
  end

  // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == S_IDLE || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  // Prefix tracking runs one cycle behind the frame result so key_valid trails byte_valid.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_valid_d = 1'b0;
    key_digit_d = key_digit_q;
    dec         = digit_of(rx_byte_q);
    if (frame_err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (byte_valid_q) begin
      if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!brk_q && !ext_q && dec[4]) begin
          key_valid_d = 1'b1;
          key_digit_d = dec[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= 8'h00;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      key_valid_q  <= 1'b0;
      key_digit_q  <= 4'hF;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      rx_byte_q    <= rx_byte_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      key_valid_q  <= key_valid_d;
      key_digit_q  <= key_digit_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;
  assign frame_err  = frame_err_q;
  assign key_valid  = key_valid_q;
  assign key_digit  = key_digit_q;

endmodule

// File: tb/tb_ps2key_digit_rx.sv
// Scoreboard bench for ps2key_digit_rx: one instance with keypad decode and one without,
// driven from the same pins; expected pulses are queued per instance and popped by monitors.
module tb_ps2key_digit_rx;

  localparam int FILT = 4;
  localparam int TOUT = 300;
  localparam int HALF = 20;
  localparam int KB = 0;
  localparam int KK = 1;
  localparam int KE = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       bv1, kv1, fe1, bv0, kv0, fe0;
  logic [7:0] rx1, rx0;
  logic [3:0] kd1, kd0;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t q1[$];
  ev_t q0[$];
  int  tests = 0;
  int  fails = 0;

  ps2key_digit_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT), .KEYPAD_EN(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(bv1), .rx_byte(rx1), .key_valid(kv1), .key_digit(kd1), .frame_err(fe1)
  );

  ps2key_digit_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT), .KEYPAD_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(bv0), .rx_byte(rx0), .key_valid(kv0), .key_digit(kd0), .frame_err(fe0)
  );

  always #5 clk = ~clk;

  task automatic expect1(input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    q1.push_back(e);
  endtask

  task automatic expect0(input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    q0.push_back(e);
  endtask

  task automatic expBoth(input int k, input logic [7:0] v);
    expect1(k, v);
    expect0(k, v);
  endtask

  task automatic popCheck(input int which, input int k, input logic [7:0] v, input string name);
    ev_t e;
    bit  empty;
    tests++;
    empty = (which == 1) ? (q1.size() == 0) : (q0.size() == 0);
    if (empty) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: unexpected pulse val=%h, no pulse required", name, which, v);
      return;
    end
    if (which == 1) e = q1.pop_front();
    else e = q0.pop_front();
    if (e.kind != k || e.val != v) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got kind=%0d val=%h, required kind=%0d val=%h",
               name, which, k, v, e.kind, e.val);
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitors: every observed pulse must match the head of that instance's queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bv1 && fe1) begin
        tests++;
        fails++;
        $display("[TB] FAIL excl dut1: byte_valid=1 frame_err=1, required not both");
      end
      if (bv1) popCheck(1, KB, rx1, "byte");
      if (kv1) popCheck(1, KK, {4'h0, kd1}, "key");
      if (fe1) popCheck(1, KE, rx1, "err");
      if (bv0 && fe0) begin
        tests++;
        fails++;
        $display("[TB] FAIL excl dut0: byte_valid=1 frame_err=1, required not both");
      end
      if (bv0) popCheck(0, KB, rx0, "byte");
      if (kv0) popCheck(0, KK, {4'h0, kd0}, "key");
      if (fe0) popCheck(0, KE, rx0, "err");
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int nBits);
    logic [10:0] f;
    f = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2_data = f[i];
      waitClk(HALF / 2);
      ps2_clk = 1'b0;
      waitClk(HALF);
      ps2_clk = 1'b1;
      waitClk(HALF / 2);
    end
    ps2_data = 1'b1;
    waitClk(2 * HALF);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] f;
    int          n;
    bit          got;

    waitClk(5);
    checkOutput("reset_rx_byte", rx1, 8'h00);
    checkOutput("reset_key_digit", kd1, 4'hF);
    checkOutput("reset_pulses", {bv1, kv1, fe1}, 0);
    checkOutput("reset_key_digit_kp0", kd0, 4'hF);
    reset_n = 1'b1;
    waitClk(10);

    expBoth(KB, 8'h16); expBoth(KK, 8'd1);
    applyStimulus(8'h16, 0, 0, 11);

    expBoth(KB, 8'h45); expBoth(KK, 8'd0);
    applyStimulus(8'h45, 0, 0, 11);
    expBoth(KB, 8'hF0);
    applyStimulus(8'hF0, 0, 0, 11);
    expBoth(KB, 8'h45);
    applyStimulus(8'h45, 0, 0, 11);

    expBoth(KE, 8'h45);
    applyStimulus(8'h1E, 1, 0, 11);

    expBoth(KE, 8'h45);
    applyStimulus(8'h26, 0, 1, 11);
    expBoth(KB, 8'h26); expBoth(KK, 8'd3);
    applyStimulus(8'h26, 0, 0, 11);

    expect1(KB, 8'h7D); expect1(KK, 8'd9);
    expect0(KB, 8'h7D);
    applyStimulus(8'h7D, 0, 0, 11);

    expBoth(KB, 8'hE0);
    applyStimulus(8'hE0, 0, 0, 11);
    expBoth(KB, 8'h75);
    applyStimulus(8'h75, 0, 0, 11);

    expBoth(KB, 8'hF0);
    applyStimulus(8'hF0, 0, 0, 11);
    expBoth(KB, 8'hE0);
    applyStimulus(8'hE0, 0, 0, 11);
    expBoth(KB, 8'h16);
    applyStimulus(8'h16, 0, 0, 11);
    expBoth(KB, 8'h16); expBoth(KK, 8'd1);
    applyStimulus(8'h16, 0, 0, 11);

    expBoth(KB, 8'hF0);
    applyStimulus(8'hF0, 0, 0, 11);
    expBoth(KE, 8'hF0);
    applyStimulus(8'h1E, 1, 0, 11);
    expBoth(KB, 8'h16); expBoth(KK, 8'd1);
    applyStimulus(8'h16, 0, 0, 11);

    expBoth(KB, 8'h3D); expBoth(KK, 8'd7);
    applyStimulus(8'h3D, 0, 0, 11);
    expBoth(KB, 8'h3D); expBoth(KK, 8'd7);
    applyStimulus(8'h3D, 0, 0, 11);

    ps2_data = 1'b0;
    waitClk(3);
    ps2_clk = 1'b0;
    waitClk(FILT - 1);
    ps2_clk = 1'b1;
    waitClk(5);
    ps2_data = 1'b1;
    waitClk(2 * HALF);
    expBoth(KB, 8'h2E); expBoth(KK, 8'd5);
    applyStimulus(8'h2E, 0, 0, 11);

    expBoth(KE, 8'h2E);
    applyStimulus(8'h36, 0, 0, 4);
    f = {2'b11, 8'h36, 1'b0};
    ps2_data = f[4];
    waitClk(HALF / 2);
    ps2_clk = 1'b0;
    n = 0;
    got = 0;
    while (n < TOUT + 100 && !got) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk = 1'b1;
      if (fe1) got = 1;
    end
    ps2_data = 1'b1;
    checkOutput("timeout_cycles", n, TOUT + FILT + 2);
    waitClk(2 * HALF);

    expBoth(KB, 8'h36); expBoth(KK, 8'd6);
    applyStimulus(8'h36, 0, 0, 11);

    applyStimulus(8'h46, 0, 0, 5);
    reset_n = 1'b0;
    waitClk(3);
    checkOutput("midreset_key_digit", kd1, 4'hF);
    checkOutput("midreset_rx_byte", rx1, 8'h00);
    checkOutput("midreset_key_digit_kp0", kd0, 4'hF);
    reset_n = 1'b1;
    waitClk(20);
    expBoth(KB, 8'h46); expBoth(KK, 8'd9);
    applyStimulus(8'h46, 0, 0, 11);

    waitClk(50);
    checkOutput("queue_dut1_drained", q1.size(), 0);
    checkOutput("queue_dut0_drained", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
